mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15: the maximum number of cycles spent waiting for mem_done before the transaction is aborted (range 1..255).
REQ-002 The block SHALL have the following ports, in this order:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch read request; held until if_done or if_err.
- if_addr  in  16  fetch address.
- if_rdata  out  16  fetch read data.
- if_done  out  1  fetch completion pulse.
- if_err  out  1  fetch error pulse.
- if_stall  out  1  fetch pipeline stall.
- dm_req  in  1  data-memory request; held until dm_done or dm_err.
- dm_wr  in  1  1 = write, 0 = read.
- dm_addr  in  16  data address.
- dm_wdata  in  16  write data.
- dm_rdata  out  16  data read data.
- dm_done  out  1  data completion pulse.
- dm_err  out  1  data error pulse.
- dm_stall  out  1  memory-stage stall.
- mem_en  out  1  backend access strobe.
- mem_wr  out  1  backend write enable.
- mem_addr  out  16  backend address.
- mem_wdata  out  16  backend write data.
- mem_rdata  in  16  backend read data.
- mem_done  in  1  backend completion.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, RESP.
REQ-004 In IDLE, a pending request SHALL be sampled; if one is granted, the granted request's wr/addr/wdata and its owner (IF or DM) SHALL be latched and the FSM SHALL move to ISSUE.
REQ-005 Arbitration when both requests are pending SHALL grant DM, unless the previous grant was DM, in which case IF SHALL be granted.
- A single pending request SHALL always be granted.
REQ-006 A granted request with addr[0]=1 SHALL NOT enter ISSUE; the owner's err output SHALL pulse for 1 cycle, in the cycle after sampling, the FSM SHALL stay in IDLE, and mem_en SHALL stay 0.
REQ-007 In ISSUE, mem_en SHALL be 1 for exactly one cycle, with mem_wr/mem_addr/mem_wdata driven from the latched values.
- mem_wr SHALL be 0 for IF grants.
REQ-008 mem_done SHALL be honoured in ISSUE or WAIT.
- If mem_done=1, the latched rdata SHALL be set to mem_rdata and the FSM SHALL move to RESP.
- If mem_done=0 in ISSUE, the FSM SHALL move to WAIT.
REQ-009 mem_addr/mem_wr/mem_wdata SHALL hold the latched values throughout ISSUE and WAIT.
REQ-010 A wait counter SHALL clear on entry to ISSUE and increment on each WAIT cycle without mem_done.
- When the counter reaches TIMEOUT, the owner's err SHALL pulse for 1 cycle, the FSM SHALL move to IDLE, and no done SHALL be issued.
REQ-011 In RESP, the owner's done SHALL be 1 for exactly one cycle, with the owner's rdata valid.
- The FSM SHALL then return to IDLE.
- Minimum latency from request sampled to done SHALL be 3 cycles (IDLE, ISSUE with mem_done, RESP).
REQ-012 if_rdata and dm_rdata SHALL hold their last captured value until the next capture for that owner.
- dm_rdata SHALL NOT update on writes.
REQ-013 The stall outputs SHALL be combinational: if_stall = if_req & ~if_done & ~if_err; dm_stall = dm_req & ~dm_done & ~dm_err.
REQ-014 Deassertion of the owner's req during ISSUE/WAIT SHALL NOT abort the transaction; done/err SHALL still pulse.
REQ-015 A request arriving while not in IDLE SHALL wait; it SHALL be arbitrated in the cycle the FSM is next in IDLE (the cycle after RESP or err).
REQ-016 mem_done asserted in IDLE or RESP SHALL be ignored.
REQ-017 done and err SHALL never be 1 together, and at most one owner SHALL receive done or err in any cycle.

Reset
REQ-018 While rst=0, the following SHALL hold, asynchronously:
- FSM = IDLE; last-grant = IF; wait counter = 0.
- mem_en, mem_wr, if_done, dm_done, if_err, dm_err = 0.
- mem_addr, mem_wdata, if_rdata, dm_rdata = 16'h0000.
REQ-019 Reset asserted during ISSUE/WAIT/RESP SHALL discard the transaction with no done or err pulse.
- The first arbitration SHALL occur in the first rising edge after rst returns to 1.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Single read: dm_req=1, dm_wr=0, dm_addr=16'h0010; mem_done in ISSUE with mem_rdata=16'hBEEF -> mem_en pulses 1 cycle with mem_addr=16'h0010; dm_done pulses 3 cycles after the request; dm_rdata=16'hBEEF; dm_stall=1 until dm_done.
- Contention: if_req and dm_req both asserted from reset, each backend response delayed 2 cycles -> grant order DM, IF, DM, IF; no starvation; mem_wr=0 on IF grants.
- Write: dm_wr=1, dm_addr=16'h0020, dm_wdata=16'h1234 -> mem_wr=1 and mem_wdata=16'h1234 throughout ISSUE/WAIT; dm_done pulses; dm_rdata unchanged.
- Unaligned: dm_addr=16'h0021 -> dm_err pulses 1 cycle; mem_en stays 0; FSM stays in IDLE.
- Timeout: mem_done held 0, TIMEOUT=15 -> owner err pulses after 15 WAIT cycles; no done; the next request is served normally.
- Reset mid-WAIT: rst=0 during WAIT -> all outputs zero immediately; no done/err after release; a fresh request then completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: fetch (IF) and data-memory (DM) requesters share one
// backend through a four-state IDLE/ISSUE/WAIT/RESP transaction engine.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_done,
    output logic        if_err,
    output logic        if_stall,
    input  logic        dm_req,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic [15:0] dm_rdata,
    output logic        dm_done,
    output logic        dm_err,
    output logic        dm_stall,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        own_q, own_d;
    logic        last_q, last_d;
    logic        wr_q, wr_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] if_rdata_q, if_rdata_d;
    logic [15:0] dm_rdata_q, dm_rdata_d;
    logic        if_done_q, if_done_d;
    logic        dm_done_q, dm_done_d;
    logic        if_err_q, if_err_d;
    logic        dm_err_q, dm_err_d;

    logic        if_pend, dm_pend;
    logic        gnt_if, gnt_dm;
    logic [15:0] sel_addr;

    // An owner whose err is pulsing still holds req this cycle; that request is finished.
    assign if_pend  = if_req & ~if_err_q;
    assign dm_pend  = dm_req & ~dm_err_q;
    assign gnt_dm   = dm_pend & (~if_pend | ~last_q);
    assign gnt_if   = if_pend & ~gnt_dm;
    assign sel_addr = gnt_dm ? dm_addr : if_addr;

    always_comb begin
        state_d    = state_q;
        own_d      = own_q;
        last_d     = last_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_done_d  = 1'b0;
        dm_done_d  = 1'b0;
        if_err_d   = 1'b0;
        dm_err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt_if | gnt_dm) begin
                    last_d = gnt_dm;
                    if (sel_addr[0]) begin
                        if_err_d = gnt_if;
                        dm_err_d = gnt_dm;
                    end else begin
                        own_d   = gnt_dm;
                        wr_d    = gnt_dm & dm_wr;
                        addr_d  = sel_addr;
                        wdata_d = gnt_dm ? dm_wdata : 16'h0000;
                        cnt_d   = 8'd0;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE, WAIT: begin
                if (mem_done) begin
                    state_d   = RESP;
                    if_done_d = ~own_q;
                    dm_done_d = own_q;
                    if (!own_q) begin
                        if_rdata_d = mem_rdata;
                    end else if (!wr_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                end else if (state_q == ISSUE) begin
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == CntLast) begin
                        state_d  = IDLE;
                        if_err_d = ~own_q;
                        dm_err_d = own_q;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            own_q      <= 1'b0;
            last_q     <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            cnt_q      <= 8'd0;
            if_rdata_q <= 16'h0000;
            dm_rdata_q <= 16'h0000;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
            if_err_q   <= 1'b0;
            dm_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            own_q      <= own_d;
            last_q     <= last_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_done_q  <= if_done_d;
            dm_done_q  <= dm_done_d;
            if_err_q   <= if_err_d;
            dm_err_q   <= dm_err_d;
        end
    end

    assign mem_en    = (state_q == ISSUE);
    assign mem_wr    = wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign if_err    = if_err_q;
    assign dm_err    = dm_err_q;
    assign if_stall  = if_req & ~if_done_q & ~if_err_q;
    assign dm_stall  = dm_req & ~dm_done_q & ~dm_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized single transactions
// checked against a cycle-count model of latency, timeout and error rules.
module tb_mem_arbiter;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_wr, mem_done;
    logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_done, if_err, if_stall;
    logic        dm_done, dm_err, dm_stall;
    logic        mem_en, mem_wr;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] m_if, m_dm;
    logic [15:0] a_if, a_dm;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_done(if_done), .if_err(if_err), .if_stall(if_stall),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_done(dm_done),
        .dm_err(dm_err), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One transaction from an idle arbiter; backend answers d cycles after ISSUE.
    task automatic run_txn(input bit dm, input bit wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input int d,
                           input logic [15:0] rd);
        bit al, ok, we;
        int ec;
        logic od, oe, xd, xe, os;
        al = ~addr[0];
        we = dm & wr;
        ok = al && (d <= TO);
        ec = !al ? 1 : (ok ? d + 2 : TO + 2);
        @(posedge clk); #1;
        if (dm) begin
            dm_req = 1'b1; dm_wr = wr; dm_addr = addr; dm_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        #1;
        chk("stall_c0", dm ? dm_stall : if_stall, 16'd1);
        chk("done_c0", {15'd0, dm_done | if_done | dm_err | if_err}, 16'd0);
        for (int c = 1; c <= ec + 1; c++) begin
            @(posedge clk); #1;
            if (c == ec + 1) begin
                if_req = 1'b0; dm_req = 1'b0;
            end
            mem_done  = (ok && c == d + 1) || (c >= ec && $urandom_range(1) == 1);
            mem_rdata = (ok && c == d + 1) ? rd : 16'($urandom);
            #1;
            od = dm ? dm_done : if_done;
            oe = dm ? dm_err : if_err;
            xd = dm ? if_done : dm_done;
            xe = dm ? if_err : dm_err;
            os = dm ? dm_stall : if_stall;
            chk("mem_en", {15'd0, mem_en}, {15'd0, al && c == 1});
            if (al && c < ec) begin
                chk("mem_addr", mem_addr, addr);
                chk("mem_wr", {15'd0, mem_wr}, {15'd0, we});
                if (we) chk("mem_wdata", mem_wdata, wdata);
            end
            chk("done", {15'd0, od}, {15'd0, ok && c == ec});
            chk("err", {15'd0, oe}, {15'd0, !ok && c == ec});
            chk("other_owner", {15'd0, xd | xe}, 16'd0);
            chk("stall", {15'd0, os}, {15'd0, c < ec});
            if (c == ec && ok && !we) begin
                if (dm) m_dm = rd;
                else m_if = rd;
            end
            if (c >= ec) begin
                chk("if_rdata", if_rdata, m_if);
                chk("dm_rdata", dm_rdata, m_dm);
            end
        end
        mem_done = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        mem_done = 1'b0; mem_rdata = 16'h0;
        dm_wr = 1'b0; dm_wdata = 16'h0;
        m_if = 16'h0; m_dm = 16'h0;
        a_if = 16'h0100; a_dm = 16'h0200;
        if_addr = a_if; dm_addr = a_dm;
        if_req = 1'b1; dm_req = 1'b1;
        #1;
        chk("rst_en", {15'd0, mem_en}, 16'd0);
        chk("rst_wr", {15'd0, mem_wr}, 16'd0);
        chk("rst_addr", mem_addr, 16'h0);
        chk("rst_wdata", mem_wdata, 16'h0);
        chk("rst_rd", if_rdata | dm_rdata, 16'h0);
        chk("rst_pulse", {15'd0, if_done | dm_done | if_err | dm_err}, 16'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Contention from reset: DM first, then strict alternation.
        for (int g = 0; g < 4; g++) begin
            bit gd;
            gd = (g % 2 == 0);
            @(posedge clk); #2;
            chk("c_en", {15'd0, mem_en}, 16'd1);
            chk("c_addr", mem_addr, gd ? a_dm : a_if);
            chk("c_wr", {15'd0, mem_wr}, 16'd0);
            chk("c_stall", {15'd0, if_stall & dm_stall}, 16'd1);
            @(posedge clk); #2;
            chk("c_en_w1", {15'd0, mem_en}, 16'd0);
            @(posedge clk); #1;
            mem_done = 1'b1; mem_rdata = 16'hA000 + 16'(g);
            #1;
            chk("c_en_w2", {15'd0, mem_en}, 16'd0);
            @(posedge clk); #1;
            mem_done = 1'b0;
            #1;
            chk("c_done_own", {15'd0, gd ? dm_done : if_done}, 16'd1);
            chk("c_done_oth", {15'd0, gd ? if_done : dm_done}, 16'd0);
            if (gd) m_dm = 16'hA000 + 16'(g);
            else m_if = 16'hA000 + 16'(g);
            chk("c_rdata", gd ? dm_rdata : if_rdata, gd ? m_dm : m_if);
            if (gd) begin
                a_dm = a_dm + 16'd2; dm_addr = a_dm;
            end else begin
                a_if = a_if + 16'd2; if_addr = a_if;
            end
            if (g == 3) begin
                if_req = 1'b0; dm_req = 1'b0;
            end
            @(posedge clk); #2;
            chk("c_idle", {15'd0, mem_en | if_done | dm_done}, 16'd0);
        end

        run_txn(1'b1, 1'b0, 16'h0010, 16'h0000, 0, 16'hBEEF);
        run_txn(1'b1, 1'b1, 16'h0020, 16'h1234, 2, 16'h5555);
        run_txn(1'b1, 1'b0, 16'h0021, 16'h0000, 0, 16'h6666);
        run_txn(1'b1, 1'b0, 16'h0030, 16'h0000, TO + 5, 16'h0BAD);
        run_txn(1'b1, 1'b0, 16'h0032, 16'h0000, 1, 16'hC0DE);
        run_txn(1'b0, 1'b0, 16'h0400, 16'h0000, TO, 16'h1111);
        run_txn(1'b0, 1'b0, 16'h0402, 16'h0000, TO + 1, 16'h2222);
        run_txn(1'b0, 1'b0, 16'h0403, 16'h0000, 0, 16'h3333);

        // Reset while waiting on the backend.
        @(posedge clk); #1;
        dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0040;
        @(posedge clk); #2;
        chk("r_issue", {15'd0, mem_en}, 16'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        m_if = 16'h0; m_dm = 16'h0;
        chk("r_en", {15'd0, mem_en | mem_wr}, 16'd0);
        chk("r_addr", mem_addr | mem_wdata, 16'h0);
        chk("r_rdata", if_rdata | dm_rdata, 16'h0);
        chk("r_pulse", {15'd0, if_done | dm_done | if_err | dm_err}, 16'd0);
        dm_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2;
            chk("r_quiet", {15'd0, mem_en | if_done | dm_done | if_err | dm_err}, 16'd0);
        end
        run_txn(1'b1, 1'b0, 16'h0044, 16'h0000, 1, 16'h7777);

        for (int i = 0; i < 40; i++) begin
            bit dm, wr;
            logic [15:0] a, wd, rd;
            int d;
            dm = 1'($urandom_range(1));
            wr = 1'($urandom_range(1));
            a  = 16'($urandom);
            a[0] = ($urandom_range(7) == 0);
            wd = 16'($urandom);
            rd = 16'($urandom);
            d  = ($urandom_range(9) == 0) ? TO + 1 + int'($urandom_range(3))
                                          : int'($urandom_range(TO));
            run_txn(dm, wr, a, wd, d, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
